// File: rtl/serial_tl_bit_adapter_if.sv
// serial_tl_bit_adapter_if: host word and serial lane handshakes plus word counters
interface serial_tl_bit_adapter_if #(parameter int W = 32, parameter int CW = 16);
  logic          tx_word_valid;
  logic          tx_word_ready;
  logic [W-1:0]  tx_word_bits;
  logic          ser_out_valid;
  logic          ser_out_ready;
  logic          ser_out_bits;
  logic          ser_in_valid;
  logic          ser_in_ready;
  logic          ser_in_bits;
  logic          rx_word_valid;
  logic          rx_word_ready;
  logic [W-1:0]  rx_word_bits;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  modport master (
    input  tx_word_valid, tx_word_bits, ser_out_ready, ser_in_valid, ser_in_bits, rx_word_ready,
    output tx_word_ready, ser_out_valid, ser_out_bits, ser_in_ready, rx_word_valid, rx_word_bits,
           tx_count, rx_count
  );
  modport slave (
    output tx_word_valid, tx_word_bits, ser_out_ready, ser_in_valid, ser_in_bits, rx_word_ready,
    input  tx_word_ready, ser_out_valid, ser_out_bits, ser_in_ready, rx_word_valid, rx_word_bits,
           tx_count, rx_count
  );
endinterface

// File: rtl/serial_tl_bit_adapter.sv
// serial_tl_bit_adapter: LSB-first 1-bit serializer/deserializer between host words and the serial TL lanes
module serial_tl_bit_adapter #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input logic clock,
  input logic reset,
  serial_tl_bit_adapter_if.master bus
);
  localparam int BW = $clog2(W);
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  tx_state_e     tx_state_q, tx_state_d;
  logic [W-1:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          rx_full_q, rx_full_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          tx_fire, ser_out_fire, ser_in_fire, rx_fire, tx_last, rx_last;
  assign bus.tx_word_ready = (tx_state_q == TX_IDLE) && !reset;
  assign bus.ser_out_valid = tx_state_q == TX_SHIFT;
  assign bus.ser_out_bits  = tx_sh_q[0];
  assign bus.ser_in_ready  = !rx_full_q && !reset;
  assign bus.rx_word_valid = rx_full_q;
  assign bus.rx_word_bits  = rx_sh_q;
  assign bus.tx_count      = tx_count_q;
  assign bus.rx_count      = rx_count_q;
  assign tx_fire      = bus.tx_word_valid && bus.tx_word_ready;
  assign ser_out_fire = bus.ser_out_valid && bus.ser_out_ready;
  assign ser_in_fire  = bus.ser_in_valid && bus.ser_in_ready;
  assign rx_fire      = bus.rx_word_valid && bus.rx_word_ready;
  assign tx_last      = tx_cnt_q == BW'(W - 1);
  assign rx_last      = rx_cnt_q == BW'(W - 1);
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_count_d = tx_count_q;
    if (tx_state_q == TX_IDLE) begin
      if (tx_fire) begin
        tx_sh_d    = bus.tx_word_bits;
        tx_cnt_d   = '0;
        tx_state_d = TX_SHIFT;
      end
    end else if (ser_out_fire) begin
      tx_sh_d    = tx_sh_q >> 1;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_state_d = tx_last ? TX_IDLE : TX_SHIFT;
      tx_count_d = tx_last ? tx_count_q + 1'b1 : tx_count_q;
    end
  end
  // the word is complete on the fire that carries bit W-1; the counter restarts for the next word
  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_cnt_d   = rx_cnt_q;
    rx_full_d  = rx_full_q;
    rx_count_d = rx_count_q;
    if (ser_in_fire) begin
      rx_sh_d   = {bus.ser_in_bits, rx_sh_q[W-1:1]};
      rx_cnt_d  = rx_last ? '0 : rx_cnt_q + 1'b1;
      rx_full_d = rx_last;
    end
    if (rx_fire) begin
      rx_full_d  = 1'b0;
      rx_count_d = rx_count_q + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tx_count_q <= '0;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_full_q  <= 1'b0;
      rx_count_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_count_q <= tx_count_d;
      rx_sh_q    <= rx_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_full_q  <= rx_full_d;
      rx_count_q <= rx_count_d;
    end
  end
endmodule
